priority_code_decoder: RTL and testbench
========================================

# priority_code_decoder

- Inverse of the 16-bit priority encoder.
- Accepts 8-bit priority codes over a valid/ready handshake and reconstructs the minimal 16-bit input vector that produces each code.
- Holds the reconstructed vector on a registered output for a programmable number of cycles, then clears it.
- Flags and counts malformed codes.
- Sits between the encoder output bus and downstream one-hot consumers, e.g. LED or status pin drivers.

## Interface

Parameters:
- HOLD_CYCLES, default 4: cycles `onehot_out` stays asserted per valid code. Legal range 1..255.
- CNT_W, default 8: width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- code_in  input  8  priority code
- code_valid  input  1  `code_in` is valid this cycle
- code_ready  output  1  block can accept a code this cycle
- onehot_out  output  16  reconstructed input vector
- out_valid  output  1  `onehot_out` is meaningful
- err  output  1  one-cycle pulse on a malformed code
- err_count  output  CNT_W  saturating count of malformed codes
- busy  output  1  FSM is in HOLD

## Operation

- Code map:
  - 0x00..0x0E (n): `onehot_out` = bit 15 set | bit n set. Example: 0x03 -> 0x8008, 0x0E -> 0xC000.
  - 0xF0: bit 15 only, 0x8000.
  - Every other value is malformed.
- Handshake:
  - A transfer occurs on a rising edge where `code_valid` and `code_ready` are both high.
  - `code_ready` = (state == IDLE) and not `rst`.
  - `code_ready` is not combinationally dependent on `code_valid`.
- FSM states: IDLE, HOLD.
- IDLE:
  - Valid code accepted: load `onehot_out`, set `out_valid` = 1, load hold counter with HOLD_CYCLES-1, go to HOLD.
  - Malformed code accepted: `err` = 1 for the next cycle, `err_count` increments (saturating at all-ones), outputs unchanged, remain in IDLE.
- HOLD:
  - `code_ready` = 0; `code_valid` is ignored.
  - Counter decrements each cycle.
  - On the edge after counter == 0: clear `onehot_out` to 0, set `out_valid` = 0, return to IDLE.
- `busy` = (state == HOLD).
- Reset values: `onehot_out` = 0, `out_valid` = 0, `err` = 0, `err_count` = 0, `busy` = 0, state IDLE, counter 0. `code_ready` = 0 while `rst` is high.

## Timing

- Latency: code accepted at edge k -> `onehot_out` and `out_valid` visible after edge k.
- `out_valid` stays high for exactly HOLD_CYCLES cycles and falls at edge k+HOLD_CYCLES.
- `code_ready` is high again in the cycle after `out_valid` falls. Minimum spacing between accepted valid codes is HOLD_CYCLES+1 cycles.
- Malformed code accepted at edge k -> `err` high for exactly one cycle after edge k. `code_ready` stays high, so back-to-back malformed codes give back-to-back `err` pulses and counts.
- HOLD_CYCLES = 1: `out_valid` is high for one cycle; the next code can be accepted two edges after the first.
- `err_count` at all-ones: `err` still pulses, count stays unchanged.
- `rst` high mid-HOLD: the next edge clears all outputs and state; no partial hold completes.
- `rst` and `code_valid` high together: the code is dropped.

## Structure

- Shared package `prio_code_pkg` holds:
  - CODE_NONE = 8'hF0
  - CODE_MAX = 8'h0E
  - ONEHOT_W = 16
  - state enum {IDLE, HOLD}
  - The encoder reuses these constants.
- Sub-module `code_to_onehot`: purely combinational; maps the 8-bit code to a 16-bit vector plus a `malformed` flag.
- The FSM, hold counter and error counter live in the top module.

## Test plan

- Reset: drive `rst` for 2 cycles with `code_valid` = 1 -> all outputs 0, `code_ready` 0; after release, `code_ready` = 1 and `err_count` = 0.
- Valid code, HOLD_CYCLES = 4: send 0x03 -> `onehot_out` = 0x8008 and `out_valid` high for exactly 4 cycles, then 0x0000. `busy` is high over the same 4 cycles. `code_ready` is low for those 4 cycles.
- Code sweep: send every code 0x00..0x0E and 0xF0 -> `onehot_out` equals bit 15 | bit n, or 0x8000 for 0xF0; `err` never asserts.
- Malformed codes: send 0x0F, 0x10, 0xFF, 0xF1 back-to-back -> four consecutive one-cycle `err` pulses, `err_count` = 4, `out_valid` stays 0.
- Saturation and backpressure:
  - CNT_W = 2, send 5 malformed codes -> `err_count` = 3.
  - Hold `code_valid` high with 0x05 then 0x07 -> 0x07 is accepted only after the first hold ends, at spacing HOLD_CYCLES+1.
- Reset mid-HOLD: assert `rst` in the 2nd HOLD cycle -> outputs 0 on the next edge; a new code sent after release decodes normally.

Source files
------------

// File: rtl/prio_code_pkg.sv
// Constants and state encoding shared by the priority encoder and its inverse decoder.
package prio_code_pkg;

  localparam int unsigned ONEHOT_W  = 16;
  localparam logic [7:0]  CODE_NONE = 8'hF0;
  localparam logic [7:0]  CODE_MAX  = 8'h0E;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

endpackage

// File: rtl/code_to_onehot.sv
// Combinational map from an 8-bit priority code to the minimal 16-bit vector
// that would produce it; bit 15 is the encoder's "none" marker, always set.
module code_to_onehot
  import prio_code_pkg::*;
(
  input  logic [7:0]          code_i,
  output logic [ONEHOT_W-1:0] onehot_o,
  output logic                malformed_o
);

  always_comb begin
    onehot_o    = '0;
    malformed_o = 1'b0;
    if (code_i <= CODE_MAX) begin
      onehot_o[ONEHOT_W-1] = 1'b1;
      onehot_o[code_i[3:0]] = 1'b1;
    end else if (code_i == CODE_NONE) begin
      onehot_o[ONEHOT_W-1] = 1'b1;
    end else begin
      malformed_o = 1'b1;
    end
  end

endmodule

// File: rtl/priority_code_decoder.sv
// Accepts priority codes over valid/ready, holds the reconstructed vector for
// HOLD_CYCLES cycles, and flags/counts malformed codes.
module priority_code_decoder
  import prio_code_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          code_in,
  input  logic                code_valid,
  output logic                code_ready,
  output logic [ONEHOT_W-1:0] onehot_out,
  output logic                out_valid,
  output logic                err,
  output logic [CNT_W-1:0]    err_count,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ONEHOT_W-1:0] onehot_q, onehot_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic [ONEHOT_W-1:0] dec_onehot;
  logic                dec_malformed;

  code_to_onehot u_dec (
    .code_i      (code_in),
    .onehot_o    (dec_onehot),
    .malformed_o (dec_malformed)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    onehot_d    = onehot_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (code_valid) begin
          if (dec_malformed) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          end else begin
            onehot_d    = dec_onehot;
            out_valid_d = 1'b1;
            cnt_d       = 8'(HOLD_CYCLES - 1);
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        // Counter reaching zero marks the last held cycle; clear on the following edge.
        if (cnt_q == '0) begin
          onehot_d    = '0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      onehot_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      onehot_q    <= onehot_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign code_ready = (state_q == IDLE) && !rst;
  assign onehot_out = onehot_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;
  assign err_count  = err_cnt_q;
  assign busy       = (state_q == HOLD);

endmodule

// File: tb/tb_priority_code_decoder.sv
// Directed bench for priority_code_decoder: one instance with default
// parameters, one with HOLD_CYCLES=1 and a 2-bit error counter.
module tb_priority_code_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_valid, a_ready, a_ov, a_err, a_busy;
  logic [7:0]  a_code, a_ecnt;
  logic [15:0] a_oh;

  logic        b_rst, b_valid, b_ready, b_ov, b_err, b_busy;
  logic [7:0]  b_code;
  logic [1:0]  b_ecnt;
  logic [15:0] b_oh;

  priority_code_decoder #(.HOLD_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(a_rst), .code_in(a_code), .code_valid(a_valid),
    .code_ready(a_ready), .onehot_out(a_oh), .out_valid(a_ov),
    .err(a_err), .err_count(a_ecnt), .busy(a_busy)
  );

  priority_code_decoder #(.HOLD_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .code_in(b_code), .code_valid(b_valid),
    .code_ready(b_ready), .onehot_out(b_oh), .out_valid(b_ov),
    .err(b_err), .err_count(b_ecnt), .busy(b_busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  bad_codes[4] = '{8'h0F, 8'h10, 8'hFF, 8'hF1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a code on A, waiting (bounded) for ready; returns just after the accepting edge.
  task automatic send_a(input logic [7:0] c);
    int unsigned n = 0;
    a_code  = c;
    a_valid = 1'b1;
    while (!a_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
  endtask

  // Called just after the accepting edge: checks the whole 4-cycle hold and the clear.
  task automatic expect_hold_a(input string tag);
    logic [15:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    for (int unsigned i = 0; i < 4; i++) begin
      chk({tag, "_oh"},    {16'd0, a_oh}, {16'd0, e});
      chk({tag, "_ov"},    {31'd0, a_ov}, 32'd1);
      chk({tag, "_busy"},  {31'd0, a_busy}, 32'd1);
      chk({tag, "_ready"}, {31'd0, a_ready}, 32'd0);
      chk({tag, "_err"},   {31'd0, a_err}, 32'd0);
      tick();
    end
    chk({tag, "_clr_oh"},    {16'd0, a_oh}, 32'd0);
    chk({tag, "_clr_ov"},    {31'd0, a_ov}, 32'd0);
    chk({tag, "_clr_busy"},  {31'd0, a_busy}, 32'd0);
    chk({tag, "_clr_ready"}, {31'd0, a_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    logic        prev;
    logic [7:0]  c;

    // Reset with code_valid high: code dropped, everything zero.
    a_rst = 1'b1; a_valid = 1'b1; a_code = 8'h03;
    b_rst = 1'b1; b_valid = 1'b1; b_code = 8'h01;
    #1;
    chk("rst_ready_comb", {31'd0, a_ready}, 32'd0);
    tick(); tick();
    chk("rst_oh",    {16'd0, a_oh}, 32'd0);
    chk("rst_ov",    {31'd0, a_ov}, 32'd0);
    chk("rst_err",   {31'd0, a_err}, 32'd0);
    chk("rst_ecnt",  {24'd0, a_ecnt}, 32'd0);
    chk("rst_busy",  {31'd0, a_busy}, 32'd0);
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ov",  {31'd0, b_ov}, 32'd0);
    a_rst = 1'b0; a_valid = 1'b0;
    b_rst = 1'b0; b_valid = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, a_ready}, 32'd1);
    chk("post_rst_ecnt",  {24'd0, a_ecnt}, 32'd0);
    tick();

    // Single valid code
    exp_q.push_back(16'h8008);
    send_a(8'h03);
    expect_hold_a("code03");

    // Full sweep of legal codes
    for (int unsigned i = 0; i < 16; i++) begin
      c = (i == 15) ? 8'hF0 : 8'(i);
      exp_q.push_back((i == 15) ? 16'h8000 : (16'h8000 | (16'h0001 << i)));
      send_a(c);
      expect_hold_a($sformatf("sweep_%02h", c));
    end

    // Back-to-back malformed codes
    a_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      a_code = bad_codes[i];
      chk("bad_ready", {31'd0, a_ready}, 32'd1);
      tick();
      chk($sformatf("bad_err_%02h", bad_codes[i]),  {31'd0, a_err}, 32'd1);
      chk($sformatf("bad_ecnt_%02h", bad_codes[i]), {24'd0, a_ecnt}, 32'(i + 1));
      chk("bad_ov", {31'd0, a_ov}, 32'd0);
    end
    a_valid = 1'b0;
    tick();
    chk("bad_err_end",  {31'd0, a_err}, 32'd0);
    chk("bad_ecnt_end", {24'd0, a_ecnt}, 32'd4);

    // Backpressure: valid held high across 0x05 then 0x07
    exp_q.push_back(16'h8020);
    exp_q.push_back(16'h8080);
    a_code = 8'h05; a_valid = 1'b1;
    chk("bp_ready", {31'd0, a_ready}, 32'd1);
    tick();
    chk("bp_first_oh", {16'd0, a_oh}, {16'd0, exp_q.pop_front()});
    a_code = 8'h07;
    n = 0; prev = 1'b1;
    while (n < 20) begin
      tick();
      n++;
      if (a_ov && !prev) break;
      prev = a_ov;
    end
    a_valid = 1'b0;
    chk("bp_spacing", n, 32'd5);
    expect_hold_a("bp_second");

    // Reset in the second HOLD cycle
    exp_q.push_back(16'h8200);
    send_a(8'h09);
    chk("mid_oh", {16'd0, a_oh}, {16'd0, exp_q.pop_front()});
    tick();
    chk("mid_busy", {31'd0, a_busy}, 32'd1);
    a_rst = 1'b1;
    #1;
    chk("mid_ready_rst", {31'd0, a_ready}, 32'd0);
    tick();
    chk("mid_oh_clr",   {16'd0, a_oh}, 32'd0);
    chk("mid_ov_clr",   {31'd0, a_ov}, 32'd0);
    chk("mid_busy_clr", {31'd0, a_busy}, 32'd0);
    chk("mid_ecnt_clr", {24'd0, a_ecnt}, 32'd0);
    a_rst = 1'b0;
    #1;
    chk("mid_ready_rel", {31'd0, a_ready}, 32'd1);
    exp_q.push_back(16'h8400);
    send_a(8'h0A);
    expect_hold_a("after_mid_rst");

    // HOLD_CYCLES = 1: next code accepted two edges after the first
    tick();
    b_code = 8'h01; b_valid = 1'b1;
    exp_q.push_back(16'h8002);
    exp_q.push_back(16'h8004);
    tick();
    chk("h1_oh0",    {16'd0, b_oh}, {16'd0, exp_q.pop_front()});
    chk("h1_ov0",    {31'd0, b_ov}, 32'd1);
    chk("h1_ready0", {31'd0, b_ready}, 32'd0);
    b_code = 8'h02;
    tick();
    chk("h1_ov1",    {31'd0, b_ov}, 32'd0);
    chk("h1_oh1",    {16'd0, b_oh}, 32'd0);
    chk("h1_ready1", {31'd0, b_ready}, 32'd1);
    tick();
    chk("h1_oh2", {16'd0, b_oh}, {16'd0, exp_q.pop_front()});
    chk("h1_ov2", {31'd0, b_ov}, 32'd1);
    b_valid = 1'b0;
    tick();
    chk("h1_ov3", {31'd0, b_ov}, 32'd0);

    // Saturating 2-bit error counter
    b_code = 8'hFF; b_valid = 1'b1;
    for (int unsigned i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("sat_err_%0d", i),  {31'd0, b_err}, 32'd1);
      chk($sformatf("sat_ecnt_%0d", i), {30'd0, b_ecnt}, (i > 3) ? 32'd3 : 32'(i));
    end
    b_valid = 1'b0;
    tick();
    chk("sat_err_end",  {31'd0, b_err}, 32'd0);
    chk("sat_ecnt_end", {30'd0, b_ecnt}, 32'd3);
    chk("sat_ov",       {31'd0, b_ov}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
